// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
//   - One operation in flight; start is sampled only in IDLE.
//   - Multiply: WIDTH-step shift-add on operand magnitudes.
//   - Divide: WIDTH-step restoring shift-subtract on operand magnitudes.
//   - FIXUP applies sign correction and writes HI/LO; DONE pulses done.
//   - MTHI/MTLO writes (hi_we/lo_we) are honoured only in IDLE, and lose to start.
// Configuration macro: MDU_SIGNED_EN
//   defined   -> op[1]=1 selects signed MULT/DIV (two's complement).
//   undefined -> op[1] is ignored; every operation is unsigned.
//   FIXUP is always one cycle, so latency is the same in both builds.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Control and architectural state (reset)
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Datapath working state (loaded at the start edge)
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]   opd_q, opd_d;     // multiplicand / divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;  // negate product / quotient
  logic               neg_rem_q, neg_rem_d;  // negate remainder
  logic               bzero_q, bzero_d;      // divide by zero pending

  // Operand decode at the start edge
  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             start_div_zero;

`ifdef MDU_SIGNED_EN
  assign op_signed = op[1];
`else
  logic unused_op_sign;
  assign unused_op_sign = op[1];
  assign op_signed      = 1'b0;
`endif

  assign a_neg          = op_signed & a[WIDTH-1];
  assign b_neg          = op_signed & b[WIDTH-1];
  assign a_mag          = a_neg ? (~a + 1'b1) : a;
  assign b_mag          = b_neg ? (~b + 1'b1) : b;
  assign start_div_zero = op[0] && (b == '0);

  // One RUN iteration for each operation type
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  // The remainder stays below the divisor, so diff[WIDTH] is a reliable borrow flag.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Sign-corrected results presented in FIXUP
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  // Next-state logic for the sequencing FSM
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_ITER) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural HI/LO and div_by_zero next values
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    dbz_d = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
        end else begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end
      S_FIXUP: begin
        if (is_div_q) begin
          hi_d  = rem_fix;
          lo_d  = quo_fix;
          dbz_d = bzero_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: load on accepted start, iterate in RUN
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    if (state_q == S_IDLE && start) begin
      cnt_d    = '0;
      opd_d    = b_mag;
      is_div_d = op[0];
      bzero_d  = start_div_zero;
      if (start_div_zero) begin
        // Divide by zero: raw a flows through unchanged into the remainder.
        acc_d     = {{WIDTH{1'b0}}, a};
        neg_res_d = 1'b0;
        neg_rem_d = 1'b0;
      end else begin
        acc_d     = {{WIDTH{1'b0}}, a_mag};
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = op[0] & a_neg;
      end
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = is_div_q ? div_next : mul_next;
    end
  end

  // State register and architectural registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath registers
  always_ff @(posedge clk) begin
    // NOTE: no reset here; every field is loaded at the start edge before it is ever read.
    cnt_q     <= cnt_d;
    acc_q     <= acc_d;
    opd_q     <= opd_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    bzero_q   <= bzero_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit (WIDTH=32).
// Expected values follow the MDU_SIGNED_EN setting of the build.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, wr_data;
  logic         hi_we, lo_we;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for exactly one edge (E0)
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count edges until done, bounded
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wr_data = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    check("rst_hi",   hi, 32'h0);
    check("rst_lo",   lo, 32'h0);
    reset = 1'b0;
    step();

    // MULTU max * max, latency from the start edge
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulu_busy_e0", 32'(busy), 32'd1);
    check("mulu_done_e0", 32'(done), 32'd0);
    check("mulu_hi_hold", hi, 32'h0);
    wait_done(lat);
    check("mulu_latency", 32'(lat), 32'd33);
    check("mulu_hi", hi, 32'hFFFF_FFFE);
    check("mulu_lo", lo, 32'h0000_0001);
    check("mulu_dbz", 32'(div_by_zero), 32'd0);
    step();
    check("mulu_done_pulse", 32'(done), 32'd0);
    check("mulu_idle_busy", 32'(busy), 32'd0);

    // DIV -7 / 2
    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check("div_latency", 32'(lat), 32'd33);
`ifdef MDU_SIGNED_EN
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
`else
    check("div_lo", lo, 32'h7FFF_FFFC);
    check("div_hi", hi, 32'h0000_0001);
`endif
    check("div_dbz", 32'(div_by_zero), 32'd0);
    step();

    // DIVU 100 / 0
    launch(2'b01, 32'd100, 32'd0);
    wait_done(lat);
    check("dz_latency", 32'(lat), 32'd33);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'd100);
    check("dz_flag", 32'(div_by_zero), 32'd1);
    step();
    step();
    step();
    check("dz_flag_held", 32'(div_by_zero), 32'd1);

    // MULT -3 * 5; the accepted start clears div_by_zero
    launch(2'b10, 32'hFFFF_FFFD, 32'd5);
    check("dz_flag_clear", 32'(div_by_zero), 32'd0);
    wait_done(lat);
    check("mul_latency", 32'(lat), 32'd33);
`ifdef MDU_SIGNED_EN
    check("mul_hi", hi, 32'hFFFF_FFFF);
`else
    check("mul_hi", hi, 32'h0000_0004);
`endif
    check("mul_lo", lo, 32'hFFFF_FFF1);
    step();

    // DIV overflow corner -2^31 / -1
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
`ifdef MDU_SIGNED_EN
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);
`else
    check("ovf_lo", lo, 32'h0000_0000);
    check("ovf_hi", hi, 32'h8000_0000);
`endif
    step();

    // DIVU 1000 / 7 and MULTU with a carry into HI
    launch(2'b01, 32'd1000, 32'd7);
    wait_done(lat);
    check("divu_lo", lo, 32'd142);
    check("divu_hi", hi, 32'd6);
    step();
    launch(2'b00, 32'h1234_5678, 32'h0000_0010);
    wait_done(lat);
    check("mulu2_hi", hi, 32'h0000_0001);
    check("mulu2_lo", lo, 32'h2345_6780);
    step();

    // Second start at E10 is ignored
    launch(2'b00, 32'd3, 32'd4);
    for (int i = 1; i <= 9; i++) step();
    op    = 2'b01;
    a     = 32'd99;
    b     = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
    check("ign_latency", 32'(lat), 32'd23);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);
    step();

    // Reset at E20 aborts the operation
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i <= 19; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    step();
    check("abort_stay_idle", 32'(busy), 32'd0);

    // MTHI / MTLO in IDLE
    hi_we   = 1'b1;
    wr_data = 32'h0000_1234;
    step();
    hi_we = 1'b0;
    check("mthi", hi, 32'h0000_1234);
    check("mthi_lo_untouched", lo, 32'h0);
    lo_we   = 1'b1;
    wr_data = 32'h0000_5678;
    step();
    lo_we = 1'b0;
    check("mtlo", lo, 32'h0000_5678);

    // MTLO while busy is ignored
    launch(2'b00, 32'd2, 32'd3);
    step();
    step();
    lo_we   = 1'b1;
    wr_data = 32'h0000_AAAA;
    step();
    lo_we = 1'b0;
    check("mtlo_busy_lo", lo, 32'h0000_5678);
    check("mtlo_busy_hi", hi, 32'h0000_1234);
    wait_done(lat);
    check("busy_run_latency", 32'(lat), 32'd30);
    check("busy_run_lo", lo, 32'd6);
    check("busy_run_hi", hi, 32'd0);
    step();

    // start together with hi_we in IDLE: start wins
    hi_we   = 1'b1;
    wr_data = 32'h0000_1111;
    step();
    check("mthi2", hi, 32'h0000_1111);
    wr_data = 32'h0000_BEEF;
    launch(2'b00, 32'd7, 32'd9);
    hi_we = 1'b0;
    check("start_wins_hi", hi, 32'h0000_1111);
    check("start_wins_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("start_wins_res_lo", lo, 32'd63);
    check("start_wins_res_hi", hi, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
